flag_raise_ctrl: RTL
====================

FLAG_RAISE_CTRL -- requirements
Module: flag_raise_ctrl

Interface
REQ-001 SHALL have parameter FLAG_TOP_Y, default 40: topmost cloth row, the fully raised position.
REQ-002 SHALL have parameter FLAG_HEIGHT, default 120: pole height in pixels.
REQ-003 SHALL have parameter FLAG_CLOTH_H, default 14: cloth height in pixels.
REQ-004 SHALL have parameter STEP_FRAMES, default 2: frame ticks per 1-pixel cloth move, legal range 1..15.
REQ-005 SHALL have parameter WAVE_FRAMES, default 8: frame ticks per wave-phase advance, legal range 1..15.
REQ-006 SHALL have port clk, input, 1 bit: single pixel-domain clock.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port frame_tick, input, 1 bit: one-cycle pulse at each vsync start.
REQ-009 SHALL have port raise_req, input, 1 bit: one-cycle raise request.
REQ-010 SHALL have port lower_req, input, 1 bit: one-cycle lower request.
REQ-011 SHALL have port cloth_top_y, output, 10 bits: current cloth top row, consumed by the renderer.
REQ-012 SHALL have port wave_phase, output, 2 bits: cloth wave animation phase.
REQ-013 SHALL have port busy, output, 1 bit: high while in RAISING or LOWERING.
REQ-014 SHALL have port raised, output, 1 bit: high in state UP.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when motion completes.

Function
REQ-016 SHALL define BOT_Y = FLAG_TOP_Y + FLAG_HEIGHT - FLAG_CLOTH_H (146 at defaults).
REQ-017 SHALL implement states DOWN, RAISING, UP and LOWERING.
REQ-018 SHALL move DOWN to RAISING on raise_req, and UP to LOWERING on lower_req, in the cycle after the request.
REQ-019 SHALL, in LOWERING, reverse to RAISING on raise_req, keeping the current cloth_top_y and clearing the step counter; in RAISING, lower_req SHALL reverse to LOWERING in the same way.
REQ-020 SHALL ignore raise_req in RAISING and UP, and ignore lower_req in LOWERING and DOWN.
REQ-021 SHALL give raise_req priority when raise_req and lower_req are asserted in the same cycle.
REQ-022 SHALL update cloth_top_y only in cycles where frame_tick=1, so the value never changes mid-frame.
REQ-023 SHALL, in RAISING/LOWERING, count frame ticks in a 4-bit step counter; on the tick that brings the count to STEP_FRAMES it SHALL move cloth_top_y by 1 (decrement when raising, increment when lowering) and clear the counter.
REQ-024 SHALL, when a request and frame_tick occur in the same cycle, apply the state change only; movement counting starts at the next tick.
REQ-025 SHALL enter UP in the cycle after cloth_top_y reaches FLAG_TOP_Y while raising, and enter DOWN in the cycle after it reaches BOT_Y while lowering.
REQ-026 SHALL pulse done for exactly 1 cycle on entry to UP or DOWN, and never pulse it on a reversal.
REQ-027 SHALL keep cloth_top_y within [FLAG_TOP_Y, BOT_Y] at all times; it never overshoots.
REQ-028 SHALL, in UP, advance wave_phase by 1 every WAVE_FRAMES ticks, wrapping from 3 to 0.
REQ-029 SHALL force wave_phase to 0 and clear the wave counter in every state other than UP.
REQ-030 SHALL ignore frame_tick when it is held high for more than 1 cycle; only the rising edge counts.

Reset
REQ-031 SHALL, while reset=1, asynchronously force: state=DOWN, cloth_top_y=BOT_Y, wave_phase=0, busy=0, raised=0, done=0, and all counters and the edge register to 0.
REQ-032 SHALL, on reset mid-motion, abandon the motion with no done pulse, and respond to requests from the first cycle after reset deasserts.

Structure
REQ-033 SHALL take typedef flag_state_t and the shared flag geometry constants from the shared package ui_pkg, so flag_renderer and this block use identical values.
REQ-034 SHALL place the frame-tick edge detect and the STEP/WAVE prescale counting in one sub-module, frame_divider, instantiated twice; all other logic SHALL be in one FSM plus the datapath.

Verification
REQ-035 SHALL verify: raise_req, then 212 frame_ticks (STEP_FRAMES=2) -> cloth_top_y 146 to 40, done pulses once, raised=1, busy=0.
REQ-036 SHALL verify: in UP, 32 frame_ticks (WAVE_FRAMES=8) -> wave_phase sequence 0,1,2,3,0; lower_req -> wave_phase=0 immediately.
REQ-037 SHALL verify: lower from 40, raise_req at cloth_top_y=100 -> reverses without a done pulse, reaches 40 after 120 more ticks.
REQ-038 SHALL verify: raise_req and lower_req in the same cycle in DOWN -> RAISING entered.
REQ-039 SHALL verify: raise_req and frame_tick in the same cycle -> cloth_top_y stays 146 until the 2nd following tick, then 145.
REQ-040 SHALL verify: reset asserted at cloth_top_y=90 mid-cycle -> outputs return to reset values asynchronously, with no done pulse.

Source files
------------

// File: rtl/ui_pkg.sv
// Shared flag geometry and state encoding for the flag controller and renderer.
// No logic; constants and types only.
// Both blocks import this so their geometry can never drift apart.
package ui_pkg;

    typedef enum logic [1:0] {
        DOWN     = 2'd0,
        RAISING  = 2'd1,
        UP       = 2'd2,
        LOWERING = 2'd3
    } flag_state_t;

    localparam int Y_W             = 10;
    localparam int FLAG_TOP_Y_DEF  = 40;
    localparam int FLAG_HEIGHT_DEF = 120;
    localparam int FLAG_CLOTH_H_DEF = 14;
    localparam int STEP_FRAMES_DEF = 2;
    localparam int WAVE_FRAMES_DEF = 8;

    // Lowest legal cloth top row: the cloth bottom sits on the pole base.
    function automatic int flag_bot_y(input int top_y, input int height, input int cloth_h);
        return top_y + height - cloth_h;
    endfunction

endpackage

// File: rtl/frame_divider.sv
// Frame-tick rising-edge detect plus a 4-bit prescaler that pulses every DIV ticks.
// Latency: div_pulse is combinational in the cycle of the DIV-th rising tick.
// No backpressure; clr or !en holds the count at zero.
module frame_divider #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic en,
    input  logic clr,
    output logic div_pulse
);

    localparam logic [3:0] LAST = 4'(DIV - 1);

    logic       tick_d;
    logic       tick_rise;
    logic [3:0] cnt;

    // A tick held high for several cycles counts once.
    assign tick_rise = frame_tick & ~tick_d;
    assign div_pulse = en & ~clr & tick_rise & (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_d <= 1'b0;
            cnt    <= 4'd0;
        end else begin
            tick_d <= frame_tick;
            if (!en || clr) begin
                cnt <= 4'd0;
            end else if (tick_rise) begin
                cnt <= div_pulse ? 4'd0 : cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/flag_raise_ctrl.sv
// Flag raise/lower sequencer: moves the cloth one row every STEP_FRAMES ticks and waves it when up.
// Latency: requests take effect the next cycle; cloth moves only on frame-tick edges.
// No backpressure; requests that do not apply in the current state are dropped.
module flag_raise_ctrl
    import ui_pkg::*;
#(
    parameter int FLAG_TOP_Y   = FLAG_TOP_Y_DEF,
    parameter int FLAG_HEIGHT  = FLAG_HEIGHT_DEF,
    parameter int FLAG_CLOTH_H = FLAG_CLOTH_H_DEF,
    parameter int STEP_FRAMES  = STEP_FRAMES_DEF,
    parameter int WAVE_FRAMES  = WAVE_FRAMES_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           frame_tick,
    input  logic           raise_req,
    input  logic           lower_req,
    output logic [Y_W-1:0] cloth_top_y,
    output logic [1:0]     wave_phase,
    output logic           busy,
    output logic           raised,
    output logic           done
);

    localparam logic [Y_W-1:0] TOP_Y = Y_W'(FLAG_TOP_Y);
    localparam logic [Y_W-1:0] BOT_Y = Y_W'(flag_bot_y(FLAG_TOP_Y, FLAG_HEIGHT, FLAG_CLOTH_H));

    flag_state_t state, state_nxt;
    logic        reversal;
    logic        step_pulse;
    logic        wave_pulse;
    logic        moving;

    assign moving = (state == RAISING) || (state == LOWERING);
    assign busy   = moving;
    assign raised = (state == UP);

    frame_divider #(.DIV(STEP_FRAMES)) u_step_div (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .en         (moving),
        .clr        (reversal),
        .div_pulse  (step_pulse)
    );

    frame_divider #(.DIV(WAVE_FRAMES)) u_wave_div (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .en         (raised),
        .clr        (1'b0),
        .div_pulse  (wave_pulse)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DOWN;
        end else begin
            state <= state_nxt;
        end
    end

    // Raise wins over lower when both arrive together; reversal beats arrival.
    always_comb begin
        state_nxt = state;
        reversal  = 1'b0;
        case (state)
            DOWN: begin
                if (raise_req) state_nxt = RAISING;
            end
            RAISING: begin
                if (lower_req && !raise_req) begin
                    state_nxt = LOWERING;
                    reversal  = 1'b1;
                end else if (cloth_top_y == TOP_Y) begin
                    state_nxt = UP;
                end
            end
            UP: begin
                if (lower_req && !raise_req) state_nxt = LOWERING;
            end
            LOWERING: begin
                if (raise_req) begin
                    state_nxt = RAISING;
                    reversal  = 1'b1;
                end else if (cloth_top_y == BOT_Y) begin
                    state_nxt = DOWN;
                end
            end
            default: state_nxt = DOWN;
        endcase
    end

    // The limit guards stop a tick landing in the single cycle spent at an end row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cloth_top_y <= BOT_Y;
            wave_phase  <= 2'd0;
            done        <= 1'b0;
        end else begin
            if (step_pulse && state == RAISING && cloth_top_y != TOP_Y) begin
                cloth_top_y <= cloth_top_y - Y_W'(1);
            end else if (step_pulse && state == LOWERING && cloth_top_y != BOT_Y) begin
                cloth_top_y <= cloth_top_y + Y_W'(1);
            end

            if (state_nxt != UP) begin
                wave_phase <= 2'd0;
            end else if (wave_pulse) begin
                wave_phase <= wave_phase + 2'd1;
            end

            done <= ((state == RAISING) && (state_nxt == UP)) ||
                    ((state == LOWERING) && (state_nxt == DOWN));
        end
    end

endmodule
